// File: rtl/urng_pair_packer_if.sv
// Handshake bundle between the Tausworthe URNG, the pair packer and the
// Box-Muller consumer: a 32-bit word stream in, a 48/16-bit pair stream out.
interface urng_pair_packer_if;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic [47:0] out_u0;
  logic [15:0] out_u1;
  logic        out_ready;

  // Producer/consumer side: drives words in, accepts pairs out.
  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_u0, out_u1
  );

  // Packer side.
  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_u0, out_u1
  );
endinterface

// File: rtl/urng_pair_packer.sv
// Packs consecutive 32-bit uniform words into (u0[47:0], u1[15:0]) pairs for
// the Box-Muller datapath, drops pairs whose u0 is zero (ln(0) undefined) and
// buffers the survivors in a first-word-fall-through FIFO.
module urng_pair_packer #(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  urng_pair_packer_if.slave  bus,
  output logic [LVL_W-1:0]   fifo_level,
  output logic [CNT_W-1:0]   zero_drop_cnt
);

  typedef enum logic {WAIT_A, WAIT_B} state_t;

  state_t             state, state_nxt;
  logic [31:0]        held_word;
  logic               in_ready;
  logic               accept;
  logic               push;
  logic               drop;
  logic               pop;
  logic [47:0]        pair_u0;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [47:0]        mem_u0 [DEPTH];
  logic [15:0]        mem_u1 [DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pair-assembly state register.
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= state_nxt;
  end

  // Next state, acceptance and push/drop decision for the word on the bus.
  // A word is always taken in WAIT_A since it only gets held; the second word
  // needs FIFO space because it completes a pair.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    in_ready  = (state == WAIT_A) || (fifo_level < LVL_W'(DEPTH));
    accept    = bus.in_valid && in_ready;
    pair_u0   = {held_word, bus.in_word[31:16]};
    case (state)
      WAIT_A: if (accept) state_nxt = WAIT_B;
      WAIT_B: begin
        if (accept) begin
          state_nxt = WAIT_A;
          if (pair_u0 == '0) drop = 1'b1;
          else               push = 1'b1;
        end
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  // First word of a pair; cleared on reset so a half pair never survives it.
  always_ff @(posedge clk) begin
    if (reset)                          held_word <= '0;
    else if (accept && state == WAIT_A) held_word <= bus.in_word;
  end

  // FIFO storage is data only; the empty-gated read below hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_u0[wr_ptr] <= pair_u0;
      mem_u1[wr_ptr] <= bus.in_word[15:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Saturating count of pairs discarded for u0 == 0.
  always_ff @(posedge clk) begin
    if (reset)     zero_drop_cnt <= '0;
    else if (drop) zero_drop_cnt <= sat_inc(zero_drop_cnt);
  end

  assign bus.out_valid = (fifo_level != '0);
  assign bus.out_u0    = bus.out_valid ? mem_u0[rd_ptr] : '0;
  assign bus.out_u1    = bus.out_valid ? mem_u1[rd_ptr] : '0;

endmodule

// File: tb/tb_urng_pair_packer.sv
// Scoreboard bench for urng_pair_packer (DEPTH = 4, CNT_W = 4).
module tb_urng_pair_packer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] zero_drop_cnt;

  urng_pair_packer_if bus ();

  urng_pair_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .fifo_level    (fifo_level),
    .zero_drop_cnt (zero_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_held;
  bit          m_half;
  logic [CNT_W-1:0] m_drop;
  bit          track;
  int          max_lvl;
  int          pop_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of pair formation: pushes expected pairs onto the scoreboard.
  task automatic model_accept(input logic [31:0] w);
    logic [47:0] u0;
    if (!m_half) begin
      m_held = w;
      m_half = 1'b1;
    end else begin
      u0 = {m_held, w[31:16]};
      if (u0 != 48'h0) exp_q.push_back({u0, w[15:0]});
      else if (m_drop != 4'hF) m_drop = m_drop + 4'h1;
      m_half = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: word %0h not accepted in %0d cycles", w, n);
    end else begin
      model_accept(w);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    exp_q.delete();
    m_half = 1'b0;
    m_held = '0;
    m_drop = '0;
  endtask

  // Monitor: every popped head pair must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (track && int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (bus.out_valid && bus.out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pair: got u0=%0h u1=%0h with empty scoreboard", bus.out_u0, bus.out_u1);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("pair_u0", {16'h0, bus.out_u0}, {16'h0, e[63:16]});
          check("pair_u1", {48'h0, bus.out_u1}, {48'h0, e[15:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    reset   = 1'b1;
    track   = 1'b0;
    max_lvl = 0;
    pop_cnt = 0;
    m_half  = 1'b0;
    m_held  = '0;
    m_drop  = '0;
    cycles(2);
    do_reset();

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop_cnt", zero_drop_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_u0", bus.out_u0, 0);
    check("rst_out_u1", bus.out_u1, 0);

    // Basic pack
    bus.out_ready = 1'b1;
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    bus.in_valid = 1'b0;
    check("basic_valid", bus.out_valid, 1);
    check("basic_u0", bus.out_u0, 48'h123456789ABC);
    check("basic_u1", bus.out_u1, 16'hDEF0);
    cycles(1);
    check("basic_level_after_pop", fifo_level, 0);

    // Zero drop, then a minimal non-zero u0 with u1 == 0
    send_word(32'h00000000);
    send_word(32'h0000FFFF);
    bus.in_valid = 1'b0;
    check("zero_drop_cnt1", zero_drop_cnt, 1);
    check("zero_drop_model", zero_drop_cnt, m_drop);
    check("zero_drop_no_valid", bus.out_valid, 0);
    send_word(32'h00000000);
    send_word(32'h00010000);
    bus.in_valid = 1'b0;
    check("min_u0_valid", bus.out_valid, 1);
    check("min_u0", bus.out_u0, 48'h000000000001);
    check("min_u1_zero", bus.out_u1, 16'h0000);
    cycles(2);

    // Backpressure: fill the FIFO, hold word 9, stall word 10
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_word(32'(i));
    check("bp_level_full", fifo_level, 4);
    check("bp_in_ready_low", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_word  = 32'd10;
    cycles(3);
    check("bp_still_full", fifo_level, 4);
    check("bp_head_u0", bus.out_u0, 48'h000000010000);
    check("bp_head_u1", bus.out_u1, 16'h0002);
    bus.out_ready = 1'b1;
    cycles(1);
    bus.out_ready = 1'b0;
    check("bp_level_after_pop", fifo_level, 3);
    check("bp_in_ready_high", bus.in_ready, 1);
    send_word(32'd10);
    bus.in_valid = 1'b0;
    check("bp_level_refull", fifo_level, 4);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && fifo_level != 0; n++) cycles(1);
    check("bp_drained", fifo_level, 0);

    // Concurrent push/pop on a steady stream
    pop_cnt = 0;
    max_lvl = 0;
    track   = 1'b1;
    for (int i = 0; i < 8; i++) send_word(32'h01010101 * (i + 1));
    bus.in_valid = 1'b0;
    cycles(3);
    track = 1'b0;
    check("stream_max_level", max_lvl, 1);
    check("stream_pair_count", pop_cnt, 4);

    // Reset with a stored pair and a half pair pending
    bus.out_ready = 1'b0;
    send_word(32'h00000005);
    send_word(32'h00000006);
    send_word(32'hAAAAAAAA);
    bus.in_valid = 1'b0;
    check("pre_rst_level", fifo_level, 1);
    do_reset();
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_u0", bus.out_u0, 0);
    check("mid_rst_drop_cnt", zero_drop_cnt, 0);
    bus.out_ready = 1'b1;
    send_word(32'h11112222);
    send_word(32'h33334444);
    bus.in_valid = 1'b0;
    check("post_rst_u0", bus.out_u0, 48'h111122223333);
    check("post_rst_u1", bus.out_u1, 16'h4444);
    cycles(2);

    // Saturation of the 4-bit drop counter
    for (int i = 0; i < 20; i++) begin
      send_word(32'h0);
      send_word(32'h0);
      if (i == 13) check("sat_cnt_14", zero_drop_cnt, 14);
    end
    bus.in_valid = 1'b0;
    check("sat_cnt_15", zero_drop_cnt, 4'hF);
    check("sat_model", zero_drop_cnt, m_drop);
    check("sat_no_valid", bus.out_valid, 0);
    cycles(3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/urng_pair_packer.md
Name: urng_pair_packer

Overview:
- Consumer-side front end for the Box-Muller datapath.
- Accepts the 32-bit uniform word stream from the Tausworthe URNG over a valid/ready handshake.
- Packs every two consecutive accepted words into one pair: a 48-bit u0 for the log/sqrt branch and a 16-bit u1 for the sin/cos branch.
- Drops pairs with u0 == 0, since ln(0) is undefined. Buffers surviving pairs in a small FIFO with a valid/ready output.

Parameters:
- DEPTH, 4: pair FIFO depth in entries; any integer >= 2.
- CNT_W, 16: width of the saturating zero-drop counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset; synchronous, active-high.
- in_valid  input  1  URNG word valid.
- in_word  input  32  URNG word.
- in_ready  output  1  packer accepts in_word this cycle.
- out_valid  output  1  FIFO head pair valid.
- out_u0  output  48  head pair u0.
- out_u1  output  16  head pair u1.
- out_ready  input  1  downstream accepts the head pair.
- fifo_level  output  clog2(DEPTH+1)  entries currently held.
- zero_drop_cnt  output  CNT_W  number of pairs discarded because u0 == 0; saturating.

Behaviour:
- Reset (synchronous, active-high, takes priority over all other events):
  - state = WAIT_A, held word = 0, FIFO emptied, fifo_level = 0, zero_drop_cnt = 0.
  - out_valid = 0; out_u0 and out_u1 read 0 while the FIFO is empty.
  - Reset mid-pair discards the held word. Reset with the FIFO non-empty discards all entries.
- Accept: a word is accepted on a rising edge when in_valid && in_ready.
- in_ready = (state == WAIT_A) || (fifo_level < DEPTH).
  - Depends on registered state only; no combinational path from out_ready.
- State machine (2 states):
  - WAIT_A, on accept: held <= in_word; go to WAIT_B.
  - WAIT_B, on accept: form u0 = {held, in_word[31:16]} and u1 = in_word[15:0]; go to WAIT_A.
    - If u0 == 0: pair discarded, zero_drop_cnt increments (holds at 2^CNT_W-1).
    - Otherwise: pair pushed to FIFO tail.
  - No accept: state unchanged.
- FIFO:
  - First-word-fall-through; out_valid = (fifo_level != 0).
  - out_u0/out_u1 show the head entry combinationally from registered storage.
  - Pop when out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
- Latency: a pushed pair is visible (out_valid = 1) in the cycle after the edge that accepted its second word.
- Simultaneous push and pop: fifo_level unchanged, both pointers advance.
- Full FIFO in WAIT_B: in_ready = 0, so a push into a full FIFO cannot occur. A pop that cycle raises in_ready on the next cycle.
- Full FIFO in WAIT_A: one word is still accepted and held.
- Pop on empty: ignored; out_ready is don't-care while out_valid = 0.
- Output data changes only on a pop, or on a push into an empty FIFO.
- u1 == 0 is legal and is not dropped.
- Word order preserved: first word forms the MSBs of u0.

Test Plan:
- Basic pack: after reset, feed 32'h12345678 then 32'h9ABCDEF0, out_ready = 1 -> next cycle out_valid = 1, out_u0 = 48'h123456789ABC, out_u1 = 16'hDEF0; after pop, fifo_level = 0.
- Zero drop: feed 32'h00000000 then 32'h0000FFFF -> no push, zero_drop_cnt = 1, out_valid stays 0. Then feed 32'h0 and 32'h00010000 -> pushed, out_u0 = 48'h000000000001, out_u1 = 16'h0000.
- Backpressure, DEPTH = 4, out_ready = 0, in_valid held high with words 1..10:
  - Words 1-8 form 4 pairs; fifo_level = 4.
  - Word 9 accepted and held (WAIT_A); in_ready then = 0 in WAIT_B.
  - Raise out_ready for one cycle -> pair {1, 2[31:16]} popped; word 10 accepted next cycle; FIFO order preserved.
- Concurrent push/pop: steady stream with out_ready = 1 every cycle -> fifo_level never exceeds 1; pair output rate is one per two words.
- Reset mid-operation: accept 32'hAAAAAAAA, assert reset one cycle, then feed 32'h11112222 and 32'h33334444 -> out_u0 = 48'h111122223333, out_u1 = 16'h4444; the held word is not used.
- Saturation, CNT_W = 4: feed 20 all-zero word pairs -> zero_drop_cnt reaches 15 and holds; no pushes occur.
